// File: rtl/pipe_barrel_shifter.sv
`default_nettype none
// =============================================================================
// Module   : pipe_barrel_shifter
// Brief    : Pipelined log-shifter (SLL/SRL/SRA/ROR), one shift level per stage,
//            valid/ready handshake with whole-pipe stall.
// Revision : 1.0 - initial release
// =============================================================================
module pipe_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)   // derived from WIDTH; leave at default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] src,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       op,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] res,
    output logic             res_zero
);

    localparam logic [1:0]       c_OP_SLL = 2'b00;
    localparam logic [1:0]       c_OP_SRL = 2'b01;
    localparam logic [1:0]       c_OP_SRA = 2'b10;
    localparam logic [WIDTH-1:0] c_ONES   = {WIDTH{1'b1}};

    // Stage registers
    logic             r_vld  [AMT_W];
    logic [WIDTH-1:0] r_data [AMT_W];
    logic [AMT_W-1:0] r_amt  [AMT_W];
    logic [1:0]       r_op   [AMT_W];
    logic             r_sign [AMT_W];

    // Per-stage inputs and shifted data
    logic             w_vin  [AMT_W];
    logic [WIDTH-1:0] w_din  [AMT_W];
    logic [AMT_W-1:0] w_ain  [AMT_W];
    logic [1:0]       w_oin  [AMT_W];
    logic             w_sin  [AMT_W];
    logic [WIDTH-1:0] w_dsh  [AMT_W];

    logic             w_adv;

    assign w_adv    = ~r_vld[AMT_W-1] | out_rdy;
    assign in_rdy   = w_adv;
    assign out_vld  = r_vld[AMT_W-1];
    assign res      = r_data[AMT_W-1];
    assign res_zero = (r_data[AMT_W-1] == '0);

    always_comb begin
        w_vin[0] = in_vld;
        w_din[0] = src;
        w_ain[0] = amt;
        w_oin[0] = op;
        w_sin[0] = src[WIDTH-1];
        for (int k = 1; k < AMT_W; k++) begin
            w_vin[k] = r_vld[k-1];
            w_din[k] = r_data[k-1];
            w_ain[k] = r_amt[k-1];
            w_oin[k] = r_op[k-1];
            w_sin[k] = r_sign[k-1];
        end
        // Stage k shifts by 2^k when amt[k] is set; the SRA fill uses the
        // original operand sign carried alongside the data.
        for (int k = 0; k < AMT_W; k++) begin
            w_dsh[k] = w_din[k];
            if (w_ain[k][k]) begin
                case (w_oin[k])
                    c_OP_SLL: w_dsh[k] = w_din[k] << (1 << k);
                    c_OP_SRL: w_dsh[k] = w_din[k] >> (1 << k);
                    c_OP_SRA: w_dsh[k] = (w_din[k] >> (1 << k)) |
                                         (w_sin[k] ? ~(c_ONES >> (1 << k)) : '0);
                    default:  w_dsh[k] = (w_din[k] >> (1 << k)) |
                                         (w_din[k] << (WIDTH - (1 << k)));
                endcase
            end
        end
    end

    // Payload only loads alongside a valid beat, so res holds through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < AMT_W; k++) begin
                r_vld[k]  <= 1'b0;
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_op[k]   <= '0;
                r_sign[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < AMT_W; k++) begin
                r_vld[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_data[k] <= w_dsh[k];
                    r_amt[k]  <= w_ain[k];
                    r_op[k]   <= w_oin[k];
                    r_sign[k] <= w_sin[k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_barrel_shifter.sv
`default_nettype none
// Bench for pipe_barrel_shifter: directed vector table, stall/reset sequences,
// and randomized scoreboard runs at WIDTH=16 and WIDTH=32.
module tb_pipe_barrel_shifter;

    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    // 16-bit instance
    logic        in_vld, in_rdy, out_vld, out_rdy, res_zero;
    logic [15:0] src, res;
    logic [3:0]  amt;
    logic [1:0]  op;
    // 32-bit instance
    logic        in_vld_b, in_rdy_b, out_vld_b, out_rdy_b, res_zero_b;
    logic [31:0] src_b, res_b;
    logic [4:0]  amt_b;
    logic [1:0]  op_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_barrel_shifter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .src(src),
        .amt(amt), .op(op), .out_vld(out_vld), .out_rdy(out_rdy), .res(res),
        .res_zero(res_zero)
    );

    pipe_barrel_shifter #(.WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .in_vld(in_vld_b), .in_rdy(in_rdy_b), .src(src_b),
        .amt(amt_b), .op(op_b), .out_vld(out_vld_b), .out_rdy(out_rdy_b), .res(res_b),
        .res_zero(res_zero_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: single-step shift of a w-bit value by a, using 64-bit arithmetic.
    function automatic logic [63:0] model(input int w, input logic [63:0] s,
                                          input int a, input logic [1:0] o);
        logic [63:0]        mask;
        logic [63:0]        v;
        logic signed [63:0] sx;
        mask = (64'd1 << w) - 64'd1;
        v    = s & mask;
        case (o)
            SLL:     return (v << a) & mask;
            SRL:     return v >> a;
            SRA: begin
                sx = v[w-1] ? signed'(v | ~mask) : signed'(v);
                return 64'(sx >>> a) & mask;
            end
            default: return ((v >> a) | (v << (w - a))) & mask;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [15:0] src;
        logic [3:0]  amt;
        logic [15:0] exp;
    } vec_t;

    // Drive one beat, wait for it, check latency and result.
    task automatic run_vec(input string name, input logic [1:0] o, input logic [15:0] s,
                           input logic [3:0] a, input logic [15:0] e);
        int lat;
        @(negedge clk);
        in_vld = 1'b1; src = s; amt = a; op = o; out_rdy = 1'b1;
        #1;
        check({name, "_in_rdy"}, 64'(in_rdy), 64'd1);
        @(negedge clk);
        in_vld = 1'b0;
        lat = 1;
        while (!out_vld && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_res"}, 64'(res), 64'(e));
        check({name, "_res_zero"}, 64'(res_zero), 64'(e == 16'h0));
    endtask

    vec_t        vecs [12];
    logic [63:0] q16 [$];
    logic [63:0] q32 [$];

    initial begin
        logic [63:0] e;
        logic [31:0] rnd;
        logic [15:0] held;
        logic        stalled;
        int          bi, oi, stale;

        rst = 1'b1;
        in_vld = 1'b0; src = '0; amt = '0; op = '0; out_rdy = 1'b1;
        in_vld_b = 1'b0; src_b = '0; amt_b = '0; op_b = '0; out_rdy_b = 1'b1;

        vecs[0]  = '{SRA, 16'h8001, 4'd4,  16'hF800};
        vecs[1]  = '{SRL, 16'h8001, 4'd4,  16'h0800};
        vecs[2]  = '{SLL, 16'h8001, 4'd15, 16'h8000};
        vecs[3]  = '{SLL, 16'h0001, 4'd0,  16'h0001};
        vecs[4]  = '{ROR, 16'h1234, 4'd4,  16'h4123};
        vecs[5]  = '{SRL, 16'h0001, 4'd1,  16'h0000};
        vecs[6]  = '{SRA, 16'h8000, 4'd15, 16'hFFFF};
        vecs[7]  = '{SRA, 16'h7FFF, 4'd15, 16'h0000};
        vecs[8]  = '{ROR, 16'h8001, 4'd0,  16'h8001};
        vecs[9]  = '{ROR, 16'h0001, 4'd15, 16'h0002};
        vecs[10] = '{SLL, 16'h1234, 4'd8,  16'h3400};
        vecs[11] = '{SRA, 16'h4000, 4'd3,  16'h0800};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_res_zero", 64'(res_zero), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_in_rdy", 64'(in_rdy), 64'd1);

        // Directed vector table
        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].src, vecs[i].amt, vecs[i].exp);

        // Back-to-back stream with a 3-cycle downstream stall
        bi = 0; oi = 0;
        for (int c = 0; c < 40 && oi < 8; c++) begin
            @(negedge clk);
            out_rdy = !(c >= 6 && c <= 8);
            in_vld  = (bi < 8);
            src     = 16'(bi + 1);
            amt     = 4'd1;
            op      = SLL;
            #1;
            if (out_vld && !out_rdy) begin
                check("stall_in_rdy", 64'(in_rdy), 64'd0);
                check("stall_res_hold", 64'(res), 64'(2 * (oi + 1)));
            end
            if (in_vld && in_rdy) bi++;
            if (out_vld && out_rdy) begin
                check("stream_res", 64'(res), 64'(2 * (oi + 1)));
                oi++;
            end
        end
        @(negedge clk);
        in_vld = 1'b0; out_rdy = 1'b1;
        check("stream_count", 64'(oi), 64'd8);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_vld) stale++;
        end
        check("stream_no_dup", 64'(stale), 64'd0);

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_vld = 1'b1; src = 16'(5 + i); amt = 4'd0; op = SLL; out_rdy = 1'b0;
        end
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        check("midrst_pre_vld", 64'(out_vld), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_vld", 64'(out_vld), 64'd0);
        check("midrst_res", 64'(res), 64'd0);
        @(negedge clk);
        rst = 1'b0; out_rdy = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_vld) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'd0);
        run_vec("post_rst", ROR, 16'h0001, 4'd1, 16'h8000);

        // Random regression on both widths
        stalled = 1'b0; held = '0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            if (stalled && out_vld)
                check("rnd16_stall_hold", 64'(res), 64'(held));
            rnd = $urandom;
            in_vld  = ($urandom_range(0, 3) != 0);
            src     = rnd[15:0];
            amt     = 4'($urandom_range(0, 15));
            op      = 2'($urandom_range(0, 3));
            out_rdy = ($urandom_range(0, 3) != 0);
            in_vld_b  = ($urandom_range(0, 3) != 0);
            src_b     = $urandom;
            amt_b     = 5'($urandom_range(0, 31));
            op_b      = 2'($urandom_range(0, 3));
            out_rdy_b = ($urandom_range(0, 2) != 0);
            #1;
            if (in_vld && in_rdy) q16.push_back(model(16, 64'(src), int'(amt), op));
            if (in_vld_b && in_rdy_b) q32.push_back(model(32, 64'(src_b), int'(amt_b), op_b));
            if (out_vld && out_rdy) begin
                if (q16.size() == 0) check("rnd16_spurious", 64'(out_vld), 64'd0);
                else begin
                    e = q16.pop_front();
                    check("rnd16_res", 64'(res), e);
                    check("rnd16_res_zero", 64'(res_zero), 64'(e == 0));
                end
            end
            if (out_vld_b && out_rdy_b) begin
                if (q32.size() == 0) check("rnd32_spurious", 64'(out_vld_b), 64'd0);
                else begin
                    e = q32.pop_front();
                    check("rnd32_res", 64'(res_b), e);
                    check("rnd32_res_zero", 64'(res_zero_b), 64'(e == 0));
                end
            end
            stalled = out_vld && !out_rdy;
            held    = res;
        end

        // Drain
        in_vld = 1'b0; in_vld_b = 1'b0; out_rdy = 1'b1; out_rdy_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_vld && q16.size() != 0) begin
                e = q16.pop_front();
                check("drain16_res", 64'(res), e);
            end
            if (out_vld_b && q32.size() != 0) begin
                e = q32.pop_front();
                check("drain32_res", 64'(res_b), e);
            end
        end
        check("drain16_empty", 64'(q16.size()), 64'd0);
        check("drain32_empty", 64'(q32.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
